// File: rtl/onehot_encoder_pkg.sv
// Shared types and constants for the registered 4-to-2 one-hot encoder.
// Holds the FSM state encoding, the input class encoding, the output code
// constants and the error counter saturation value.
package onehot_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CL_ZERO  = 2'd0,
        CL_ONE   = 2'd1,
        CL_MULTI = 2'd2
    } class_t;

    localparam logic [1:0] CODE_A = 2'b00;
    localparam logic [1:0] CODE_B = 2'b01;
    localparam logic [1:0] CODE_C = 2'b10;
    localparam logic [1:0] CODE_D = 2'b11;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/onehot_classify.sv
// Combinational classifier: maps vec={a,b,c,d} to ZERO/ONE/MULTI plus a 2-bit code.
// Ports: i_vec (a is the MSB), o_class, o_code (CODE_A when not ONE).
// Macro ONEHOT_ENCODER_PRIORITY_EN: multi-hot resolves to the highest line (d>c>b>a).
module onehot_classify
    import onehot_encoder_pkg::*;
(
    input  logic [3:0] i_vec,
    output class_t     o_class,
    output logic [1:0] o_code
);

    always_comb begin
        o_class = CL_ZERO;
        o_code  = CODE_A;
`ifdef ONEHOT_ENCODER_PRIORITY_EN
        // d sits in bit 0, so it is tested first to win over the others.
        if (i_vec[0]) begin
            o_class = CL_ONE;
            o_code  = CODE_D;
        end else if (i_vec[1]) begin
            o_class = CL_ONE;
            o_code  = CODE_C;
        end else if (i_vec[2]) begin
            o_class = CL_ONE;
            o_code  = CODE_B;
        end else if (i_vec[3]) begin
            o_class = CL_ONE;
            o_code  = CODE_A;
        end
`else
        case (i_vec)
            4'b0000: o_class = CL_ZERO;
            4'b1000: begin o_class = CL_ONE; o_code = CODE_A; end
            4'b0100: begin o_class = CL_ONE; o_code = CODE_B; end
            4'b0010: begin o_class = CL_ONE; o_code = CODE_C; end
            4'b0001: begin o_class = CL_ONE; o_code = CODE_D; end
            default: o_class = CL_MULTI;
        endcase
`endif
    end

endmodule

// File: rtl/onehot_encoder.sv
// Registered 4-to-2 encoder with stability filter and multi-hot fault detection.
// Ports: clk, reset (sync, active-high), a/b/c/d in; x1/x2 code, valid, changed pulse,
//        sticky error, saturating err_count out. Macro: ONEHOT_ENCODER_PRIORITY_EN.
module onehot_encoder
    import onehot_encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       x1,
    output logic       x2,
    output logic       valid,
    output logic       changed,
    output logic       error,
    output logic [7:0] err_count
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    state_t     r_state;
    logic [1:0] r_cand;
    logic [3:0] r_cnt;
    logic [1:0] r_code;
    logic       r_valid;
    logic       r_changed;
    logic       r_error;
    logic [7:0] r_err_count;

    state_t     w_state_nxt;
    logic [1:0] w_cand_nxt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] w_code_nxt;
    logic       w_valid_nxt;
    logic       w_changed_nxt;
    logic       w_error_nxt;
    logic [7:0] w_err_count_nxt;

    class_t     w_class;
    logic [1:0] w_code;
    logic [3:0] w_cnt_inc;
    logic       w_new_cand;
    logic       w_publish;
    logic       w_fault_entry;
    logic [1:0] w_pub_code;

    onehot_classify u_classify (
        .i_vec   ({a, b, c, d}),
        .o_class (w_class),
        .o_code  (w_code)
    );

    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_cnt_nxt       = r_cnt;
        w_code_nxt      = r_code;
        w_valid_nxt     = r_valid;
        w_changed_nxt   = 1'b0;
        w_error_nxt     = r_error;
        w_err_count_nxt = r_err_count;
        w_new_cand      = 1'b0;
        w_publish       = 1'b0;
        w_fault_entry   = 1'b0;
        w_pub_code      = r_cand;

        // First decide which kind of transition happens, then apply its effects once.
        case (r_state)
            ST_IDLE: begin
                if (w_class == CL_ONE)        w_new_cand    = 1'b1;
                else if (w_class == CL_MULTI) w_fault_entry = 1'b1;
            end
            ST_SETTLE: begin
                if (w_class == CL_ONE) begin
                    if (w_code == r_cand) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == STABLE_N) w_publish = 1'b1;
                    end else begin
                        w_new_cand = 1'b1;
                    end
                end else if (w_class == CL_MULTI) begin
                    w_fault_entry = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_LOCKED: begin
                // r_cand still equals the published code while locked.
                if (w_class == CL_ONE) begin
                    if (w_code != r_cand) w_new_cand = 1'b1;
                end else if (w_class == CL_MULTI) begin
                    w_fault_entry = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                // FAULT: only an all-zero input releases it.
                if (w_class == CL_ZERO) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b0;
                end
            end
        endcase

        if (w_new_cand) begin
            w_cand_nxt = w_code;
            w_cnt_nxt  = 4'd1;
            // A one-sample filter publishes on the very first sample.
            if (STABLE_N == 4'd1) begin
                w_publish  = 1'b1;
                w_pub_code = w_code;
            end else begin
                w_state_nxt = ST_SETTLE;
            end
        end

        if (w_publish) begin
            w_code_nxt    = w_pub_code;
            w_valid_nxt   = 1'b1;
            w_changed_nxt = 1'b1;
            w_state_nxt   = ST_LOCKED;
        end

        if (w_fault_entry) begin
            w_state_nxt = ST_FAULT;
            w_error_nxt = 1'b1;
            w_valid_nxt = 1'b0;
            if (r_err_count != ERR_MAX) w_err_count_nxt = r_err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cand      <= CODE_A;
            r_cnt       <= 4'd0;
            r_code      <= CODE_A;
            r_valid     <= 1'b0;
            r_changed   <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_code      <= w_code_nxt;
            r_valid     <= w_valid_nxt;
            r_changed   <= w_changed_nxt;
            r_error     <= w_error_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign x1        = r_code[1];
    assign x2        = r_code[0];
    assign valid     = r_valid;
    assign changed   = r_changed;
    assign error     = r_error;
    assign err_count = r_err_count;

endmodule
